// File: rtl/roimager_readout_seq.sv
// Row readout sequencer: takes a frame hand-off from the exposure FSM, scans every
// pixel row with correlated double sampling (signal sample, row reset, reset sample).
module roimager_readout_seq #(
  parameter int C_NUM_ROWS     = 160,
  parameter int C_ROW_SETTLE   = 20,
  parameter int C_RST_CYC      = 10,
  parameter int C_BUSY_LAT     = 2,
  parameter int C_CONV_TIMEOUT = 1024
) (
  input  logic       CLK_HS,
  input  logic       RESET,
  input  logic       FSMIND1,
  output logic       FSMIND1ACK,
  output logic       FSMIND0,
  input  logic       FSMIND0ACK,
  output logic [7:0] ROW_ADDR,
  output logic       ROW_SEL,
  output logic       PIXRES_ROW,
  output logic       ADC_SAMP,
  output logic       SAMP_TYPE,
  input  logic       ADC_BUSY,
  output logic       ERR_TIMEOUT,
  output logic [7:0] fsm_stat
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'h0,
    S_SET_SIG  = 4'h1,
    S_SAMP_SIG = 4'h2,
    S_WAIT_SIG = 4'h3,
    S_RST      = 4'h4,
    S_SET_RST  = 4'h5,
    S_SAMP_RST = 4'h6,
    S_WAIT_RST = 4'h7,
    S_NEXT     = 4'h8,
    S_HANDBACK = 4'h9,
    S_RELEASE  = 4'hA
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(C_ROW_SETTLE - 1);
  localparam logic [CW-1:0] RST_LAST     = CW'(C_RST_CYC - 1);
  localparam logic [CW-1:0] LAT_LAST     = CW'((C_BUSY_LAT > 0) ? C_BUSY_LAT - 1 : 0);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(C_CONV_TIMEOUT - 1);
  localparam logic [7:0]    ROW_LAST     = 8'(C_NUM_ROWS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      row_q, row_d;
  logic            err_q, err_d;

  // Cycle counter restarts at 0 on every state change; timed states compare against *_LAST.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    row_d   = row_q;
    err_d   = err_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (FSMIND1) begin
        state_d = S_SET_SIG;
        row_d   = '0;
      end
      S_SET_SIG:  if (cnt_q == SETTLE_LAST) state_d = S_SAMP_SIG;
      S_SAMP_SIG: state_d = S_WAIT_SIG;
      S_WAIT_SIG, S_WAIT_RST: begin
        if (cnt_q >= LAT_LAST && !ADC_BUSY) begin
          state_d = (state_q == S_WAIT_SIG) ? S_RST : S_NEXT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = (state_q == S_WAIT_SIG) ? S_RST : S_NEXT;
        end
      end
      S_RST:      if (cnt_q == RST_LAST) state_d = S_SET_RST;
      S_SET_RST:  if (cnt_q == SETTLE_LAST) state_d = S_SAMP_RST;
      S_SAMP_RST: state_d = S_WAIT_RST;
      S_NEXT: begin
        if (row_q != ROW_LAST) begin
          row_d   = row_q + 8'd1;
          state_d = S_SET_SIG;
        end else begin
          state_d = S_HANDBACK;
        end
      end
      S_HANDBACK: if (FSMIND0ACK) state_d = S_RELEASE;
      // Holding here until the request drops keeps a stale FSMIND1 from re-triggering.
      S_RELEASE:  if (!FSMIND1) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are registered from the next state so they change cleanly with the state code.
  always_ff @(posedge CLK_HS or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      err_q      <= 1'b0;
      FSMIND1ACK <= 1'b0;
      FSMIND0    <= 1'b0;
      ROW_SEL    <= 1'b0;
      PIXRES_ROW <= 1'b0;
      ADC_SAMP   <= 1'b0;
      SAMP_TYPE  <= 1'b0;
      fsm_stat   <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      err_q      <= err_d;
      FSMIND1ACK <= !(state_d inside {S_IDLE, S_RELEASE});
      FSMIND0    <= (state_d == S_HANDBACK);
      ROW_SEL    <= (state_d inside {S_SET_SIG, S_SAMP_SIG, S_WAIT_SIG, S_RST,
                                     S_SET_RST, S_SAMP_RST, S_WAIT_RST});
      PIXRES_ROW <= (state_d == S_RST);
      ADC_SAMP   <= (state_d inside {S_SAMP_SIG, S_SAMP_RST});
      SAMP_TYPE  <= (state_d == S_SAMP_RST);
      fsm_stat   <= {4'h0, state_d};
    end
  end

  assign ROW_ADDR    = row_q;
  assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_roimager_readout_seq.sv
// Directed bench for roimager_readout_seq: frame timing, ADC busy handling, timeout,
// hand-back/release protocol and asynchronous reset abort.
module tb_roimager_readout_seq;

  localparam int TO = 64;  // shortened conversion timeout so a stuck-busy frame stays short

  logic       CLK_HS = 1'b0;
  logic       RESET = 1'b1;
  logic       FSMIND1 = 1'b0;
  logic       FSMIND0ACK = 1'b0;
  logic       ADC_BUSY = 1'b0;
  logic       FSMIND1ACK, FSMIND0, ROW_SEL, PIXRES_ROW, ADC_SAMP, SAMP_TYPE, ERR_TIMEOUT;
  logic [7:0] ROW_ADDR, fsm_stat;

  roimager_readout_seq #(.C_CONV_TIMEOUT(TO)) dut (
    .CLK_HS(CLK_HS), .RESET(RESET),
    .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK),
    .ROW_ADDR(ROW_ADDR), .ROW_SEL(ROW_SEL), .PIXRES_ROW(PIXRES_ROW),
    .ADC_SAMP(ADC_SAMP), .SAMP_TYPE(SAMP_TYPE), .ADC_BUSY(ADC_BUSY),
    .ERR_TIMEOUT(ERR_TIMEOUT), .fsm_stat(fsm_stat)
  );

  always #5 CLK_HS = ~CLK_HS;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge CLK_HS) cyc <= cyc + 1;

  // ADC model: busy for busy_len cycles starting in the strobe cycle, or stuck high.
  int busy_len = 0;
  bit busy_stuck = 1'b0;
  int busy_rem = 0;
  always @(negedge CLK_HS) begin
    if (ADC_SAMP) busy_rem = busy_len;
    else if (busy_rem > 0) busy_rem = busy_rem - 1;
    ADC_BUSY = busy_stuck || (busy_rem > 0);
  end

  // Passive monitor statistics, cleared on request from the stimulus block.
  int clr_gen = 0, clr_seen = 0;
  int sig_n, rsamp_n, wrun, wait_min, wait_max, pix_run, pix_runs, pix_bad, phase;
  int row_bad, row_max, ind0_run, ind0_len, err_drop;
  logic [7:0] row_prev;
  logic pix_prev, ind0_prev, err_prev;
  always @(negedge CLK_HS) begin
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      sig_n = 0; rsamp_n = 0; wrun = 0; wait_min = 32'h7fffffff; wait_max = 0;
      pix_run = 0; pix_runs = 0; pix_bad = 0; phase = 0;
      row_bad = 0; row_max = 0; ind0_run = 0; ind0_len = 0; err_drop = 0;
    end
    if (fsm_stat == 8'h03 || fsm_stat == 8'h07) wrun = wrun + 1;
    else if (wrun > 0) begin
      if (wrun < wait_min) wait_min = wrun;
      if (wrun > wait_max) wait_max = wrun;
      wrun = 0;
    end
    if (ADC_SAMP && !SAMP_TYPE) begin sig_n = sig_n + 1; phase = 1; end
    if (PIXRES_ROW) begin
      if (phase != 1) pix_bad = pix_bad + 1;
      pix_run = pix_run + 1;
    end else if (pix_prev) begin
      if (pix_run != 10) pix_bad = pix_bad + 1;
      pix_runs = pix_runs + 1; pix_run = 0; phase = 2;
    end
    if (ADC_SAMP && SAMP_TYPE) begin
      if (phase != 2) pix_bad = pix_bad + 1;
      rsamp_n = rsamp_n + 1; phase = 0;
    end
    if (ROW_ADDR != row_prev && ROW_ADDR != 8'd0 && ROW_ADDR != row_prev + 8'd1) row_bad = row_bad + 1;
    if (int'(ROW_ADDR) > row_max) row_max = int'(ROW_ADDR);
    if (FSMIND0) ind0_run = ind0_run + 1;
    else if (ind0_prev) begin ind0_len = ind0_run; ind0_run = 0; end
    if (err_prev && !ERR_TIMEOUT && !RESET) err_drop = err_drop + 1;
    row_prev = ROW_ADDR; pix_prev = PIXRES_ROW; ind0_prev = FSMIND0; err_prev = ERR_TIMEOUT;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    clr_gen++;
    @(negedge CLK_HS);
    @(negedge CLK_HS);
  endtask

  task automatic start_frame(input string tag, output int ack_cyc);
    @(negedge CLK_HS);
    FSMIND1 = 1'b1;
    @(posedge CLK_HS);
    #1;
    ack_cyc = cyc;
    check(tag, {14'd0, FSMIND1ACK, ROW_SEL, ROW_ADDR, fsm_stat}, {14'd0, 1'b1, 1'b1, 8'h00, 8'h01});
  endtask

  task automatic wait_ind0(input string tag, input int budget);
    int n = 0;
    while (!FSMIND0 && n < budget) begin @(negedge CLK_HS); n++; end
    check(tag, {31'd0, FSMIND0}, 32'd1);
  endtask

  task automatic wait_stat(input string tag, input logic [7:0] code, input int budget);
    int n = 0;
    while (fsm_stat != code && n < budget) begin @(negedge CLK_HS); n++; end
    check(tag, {24'd0, fsm_stat}, {24'd0, code});
  endtask

  task automatic handback_quick(input string tag);
    @(negedge CLK_HS);
    FSMIND0ACK = 1'b1;
    FSMIND1 = 1'b0;
    wait_stat(tag, 8'h00, 10);
    FSMIND0ACK = 1'b0;
  endtask

  int ack_cyc;

  initial begin
    // Reset state
    repeat (3) @(negedge CLK_HS);
    check("rst_outs", {25'd0, FSMIND1ACK, FSMIND0, ROW_SEL, PIXRES_ROW, ADC_SAMP, SAMP_TYPE, ERR_TIMEOUT}, 32'd0);
    check("rst_addr_stat", {16'd0, ROW_ADDR, fsm_stat}, 32'd0);
    RESET = 1'b0;
    clear_stats();
    check("idle_hold", {24'd0, fsm_stat}, 32'd0);

    // 1: ADC idle, nominal 57-cycle rows, 160 rows
    start_frame("t1_ack", ack_cyc);
    wait_ind0("t1_ind0_seen", 20000);
    check("t1_frame_cycles", cyc - ack_cyc, 32'd9120);
    check("t1_sig_samps", sig_n, 32'd160);
    check("t1_rst_samps", rsamp_n, 32'd160);
    check("t1_wait_min", wait_min, 32'd2);
    check("t1_wait_max", wait_max, 32'd2);
    check("t1_pixres_runs", pix_runs, 32'd160);
    check("t1_pixres_bad", pix_bad, 32'd0);
    check("t1_last_row", {24'd0, ROW_ADDR}, 32'd159);
    check("t1_row_sel_off", {31'd0, ROW_SEL}, 32'd0);

    // 4: delayed hand-back acknowledge, then release held by a stale request
    repeat (99) @(negedge CLK_HS);
    FSMIND0ACK = 1'b1;
    @(negedge CLK_HS);
    FSMIND0ACK = 1'b0;
    @(negedge CLK_HS);
    check("t4_ind0_len", ind0_len, 32'd100);
    check("t4_release", {22'd0, FSMIND0, FSMIND1ACK, fsm_stat}, {22'd0, 1'b0, 1'b0, 8'h0A});
    repeat (20) @(negedge CLK_HS);
    check("t4_stay_release", {23'd0, FSMIND1ACK, fsm_stat}, {23'd0, 1'b0, 8'h0A});
    FSMIND1 = 1'b0;
    @(negedge CLK_HS);
    check("t4_idle", {24'd0, fsm_stat}, 32'd0);
    check("t4_addr_held", {24'd0, ROW_ADDR}, 32'd159);

    // 2: ADC busy 50 cycles per conversion; request dropped early is ignored
    busy_len = 50;
    clear_stats();
    start_frame("t2_ack", ack_cyc);
    repeat (5) @(negedge CLK_HS);
    FSMIND1 = 1'b0;
    wait_ind0("t2_ind0_seen", 30000);
    check("t2_frame_cycles", cyc - ack_cyc, 32'd24480);
    check("t2_wait_min", wait_min, 32'd50);
    check("t2_wait_max", wait_max, 32'd50);
    check("t2_row_mono", row_bad, 32'd0);
    check("t2_row_max", row_max, 32'd159);
    check("t2_err", {31'd0, ERR_TIMEOUT}, 32'd0);
    check("t2_sig_samps", sig_n, 32'd160);
    handback_quick("t2_back_idle");

    // 3: ADC busy stuck: every wait times out, error is sticky, scan completes
    busy_len = 0;
    busy_stuck = 1'b1;
    clear_stats();
    start_frame("t3_ack", ack_cyc);
    wait_ind0("t3_ind0_seen", 35000);
    check("t3_frame_cycles", cyc - ack_cyc, 32'd28960);
    check("t3_wait_min", wait_min, TO);
    check("t3_wait_max", wait_max, TO);
    check("t3_err", {31'd0, ERR_TIMEOUT}, 32'd1);
    check("t3_err_drop", err_drop, 32'd0);
    check("t3_rst_samps", rsamp_n, 32'd160);
    handback_quick("t3_back_idle");
    check("t3_err_sticky", {31'd0, ERR_TIMEOUT}, 32'd1);
    busy_stuck = 1'b0;

    // 5: asynchronous reset during row 37, then a fresh scan from row 0
    clear_stats();
    start_frame("t5_ack", ack_cyc);
    begin
      int n = 0;
      while (ROW_ADDR != 8'd37 && n < 4000) begin @(negedge CLK_HS); n++; end
      check("t5_row37", {24'd0, ROW_ADDR}, 32'd37);
    end
    repeat (10) @(negedge CLK_HS);
    #2;
    RESET = 1'b1;
    #1;
    check("t5_async_outs", {25'd0, FSMIND1ACK, FSMIND0, ROW_SEL, PIXRES_ROW, ADC_SAMP, SAMP_TYPE, ERR_TIMEOUT}, 32'd0);
    check("t5_async_addr_stat", {16'd0, ROW_ADDR, fsm_stat}, 32'd0);
    FSMIND1 = 1'b0;
    @(negedge CLK_HS);
    RESET = 1'b0;
    repeat (3) @(negedge CLK_HS);
    check("t5_idle", {24'd0, fsm_stat}, 32'd0);
    clear_stats();
    start_frame("t5_restart", ack_cyc);
    begin
      int n = 0;
      while (ROW_ADDR != 8'd1 && n < 200) begin @(negedge CLK_HS); n++; end
      check("t5_row_period", cyc - ack_cyc, 32'd57);
    end
    check("t5_pix_order", pix_bad, 32'd0);

    RESET = 1'b1;
    @(negedge CLK_HS);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
